dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port (rd, wr, addr, wr_data, rd_data). It services load/store requests from a single-port synchronous word SRAM, with byte, halfword and word access. Loads are sign- or zero-extended. Sub-word stores use a two-cycle read-modify-write. It sits beside riscv in the top-level, wired to the core's data-memory outputs, and returns rd_data plus a busy stall and an error flag.

---
 rtl/riscv_mem_pkg.sv | 86 ++++++++
 rtl/dmem_sram.sv | 38 +++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// ---------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the data-memory responder:
//   - RV32I load/store funct3 encodings (size in [1:0], unsigned flag in [2])
//   - responder FSM state type
//   - helpers for legality/alignment checks, lane extraction with
//     sign/zero extension, and sub-word lane merging for stores
// ---------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    function automatic logic f3_load_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic f3_store_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // size is funct3[1:0]; the reserved size 2'b11 is rejected elsewhere
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Pull the addressed lane down to bit 0, then extend to a full word.
    function automatic logic [WORD_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                       input logic [1:0]        off,
                                                       input logic [2:0]        f3);
        logic [WORD_W-1:0] sh;
        logic [WORD_W-1:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            F3_B:    res = {{24{sh[7]}},  sh[7:0]};
            F3_H:    res = {{16{sh[15]}}, sh[15:0]};
            F3_W:    res = word;
            F3_BU:   res = {24'h000000, sh[7:0]};
            F3_HU:   res = {16'h0000,   sh[15:0]};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Replace the addressed byte/half of word with the low bits of data.
    function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0] word,
                                                     input logic [WORD_W-1:0] data,
                                                     input logic [1:0]        off,
                                                     input logic [2:0]        f3);
        logic [WORD_W-1:0] mask;
        case (f3)
            F3_B:    mask = 32'h0000_00FF;
            F3_H:    mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {off, 3'b000};
        return (word & ~mask) | ((data << {off, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// ---------------------------------------------------------------------------
// dmem_sram
// Single-port synchronous word RAM with one-cycle read latency.
// A write cycle does not update dout, so dout keeps the last read word
// (the read-modify-write path relies on that).
// Ports:
//   clk   in   clock
//   en    in   access enable
//   we    in   write enable (when en)
//   addr  in   word address
//   din   in   write data
//   dout  out  read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module dmem_sram #(
    parameter int DATA_W = 32,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= din;
            end else begin
                dout <= r_mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for the core's data-memory port. Loads and word
// stores complete with a response the next cycle; byte/half stores do a
// two-cycle read-modify-write during which busy stalls the core.
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   rd, wr      in   load / store request
//   addr        in   byte address (wraps at ADDR_W bits)
//   wr_data     in   store data, sub-word taken from the low bits
//   funct3      in   RV32I load/store size and sign encoding
//   rd_data     out  load result, extended; holds between load responses
//   resp_valid  out  one-cycle pulse per accepted request
//   busy        out  request not accepted this cycle
//   err         out  with resp_valid: illegal or misaligned access
// ---------------------------------------------------------------------------
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] rd_data,
    output logic              resp_valid,
    output logic              busy,
    output logic              err
);

    localparam int WA_W = ADDR_W - 2;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_resp_valid;
    logic              r_err;
    logic              r_load_resp;
    logic [DATA_W-1:0] r_rd_data;

    // Request attributes captured at acceptance; used by the load response
    // and by the merge cycle of a sub-word store.
    logic [2:0]        r_req_f3;
    logic [1:0]        r_req_off;
    logic [WA_W-1:0]   r_req_waddr;
    logic [DATA_W-1:0] r_req_wdata;

    logic              w_accept;
    logic              w_bad;
    logic              w_resp_nxt;
    logic              w_err_nxt;
    logic              w_load_nxt;
    logic              w_sram_en;
    logic              w_sram_we;
    logic [WA_W-1:0]   w_sram_addr;
    logic [DATA_W-1:0] w_sram_din;
    logic [DATA_W-1:0] w_sram_dout;
    logic [DATA_W-1:0] w_rd_data;

    assign busy = (r_state == RMW);

    // Gating with reset keeps a request present during reset from reaching
    // the (unreset) SRAM.
    assign w_accept = (rd | wr) & ~busy & ~reset;

    assign w_bad = (rd & wr)
                 | (rd & ~f3_load_ok(funct3))
                 | (wr & ~f3_store_ok(funct3))
                 | is_misaligned(funct3[1:0], addr[1:0]);

    dmem_sram #(
        .DATA_W (DATA_W),
        .AW     (WA_W)
    ) u_sram (
        .clk  (clk),
        .en   (w_sram_en),
        .we   (w_sram_we),
        .addr (w_sram_addr),
        .din  (w_sram_din),
        .dout (w_sram_dout)
    );

    // State register and response flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_load_resp  <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_resp_nxt;
            r_err        <= w_err_nxt;
            r_load_resp  <= w_load_nxt;
            r_rd_data    <= w_rd_data;
        end
    end

    // Request capture (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req_f3    <= funct3;
            r_req_off   <= addr[1:0];
            r_req_waddr <= addr[ADDR_W-1:2];
            r_req_wdata <= wr_data;
        end
    end

    // Next-state, SRAM control and response scheduling
    always_comb begin
        w_state_nxt = r_state;
        w_sram_en   = 1'b0;
        w_sram_we   = 1'b0;
        w_sram_addr = addr[ADDR_W-1:2];
        w_sram_din  = wr_data;
        w_resp_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_load_nxt  = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_bad) begin
                        w_resp_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else if (rd) begin
                        w_sram_en  = 1'b1;
                        w_load_nxt = 1'b1;
                        w_resp_nxt = 1'b1;
                    end else if (funct3 == F3_W) begin
                        w_sram_en  = 1'b1;
                        w_sram_we  = 1'b1;
                        w_resp_nxt = 1'b1;
                    end else begin
                        // sub-word store: fetch the word, merge next cycle
                        w_sram_en   = 1'b1;
                        w_state_nxt = RMW;
                    end
                end
            end
            RMW: begin
                // dout still holds the word read when the store was accepted
                w_sram_en   = 1'b1;
                w_sram_we   = 1'b1;
                w_sram_addr = r_req_waddr;
                w_sram_din  = lane_merge(w_sram_dout, r_req_wdata, r_req_off, r_req_f3);
                w_resp_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Load data comes straight from the SRAM output in the response cycle;
    // error responses force zero; otherwise the last value is held.
    always_comb begin
        w_rd_data = r_rd_data;
        if (r_resp_valid && r_err) begin
            w_rd_data = '0;
        end else if (r_load_resp) begin
            w_rd_data = lane_extract(w_sram_dout, r_req_off, r_req_f3);
        end
    end

    assign rd_data    = w_rd_data;
    assign resp_valid = r_resp_valid;
    assign err        = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        rd      = 1'b0;
    logic        wr      = 1'b0;
    logic [8:0]  addr    = '0;
    logic [31:0] wr_data = '0;
    logic [2:0]  funct3  = '0;
    logic [31:0] rd_data;
    logic        resp_valid;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W (32),
        .ADDR_W (9)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wr_data    (wr_data),
        .funct3     (funct3),
        .rd_data    (rd_data),
        .resp_valid (resp_valid),
        .busy       (busy),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: byte-addressed memory, one expected output set
    // per cycle, derived from the request seen at each clock edge.
    // ------------------------------------------------------------------
    logic [7:0]  mb [0:511];
    bit          m_busy = 1'b0;
    int          p_addr;
    int          p_n;
    logic [31:0] p_data;
    logic        e_valid = 1'b0;
    logic        e_err   = 1'b0;
    logic        e_busy  = 1'b0;
    logic [31:0] e_rd    = '0;

    task automatic model_step();
        int          n;
        int          a;
        bit          bad;
        logic [31:0] v;
        e_valid = 1'b0;
        e_err   = 1'b0;
        a = int'(addr);
        if (m_busy) begin
            for (int i = 0; i < p_n; i++) mb[p_addr + i] = p_data[8*i +: 8];
            m_busy  = 1'b0;
            e_valid = 1'b1;
        end else if (rd || wr) begin
            case (funct3[1:0])
                2'b00:   n = 1;
                2'b01:   n = 2;
                2'b10:   n = 4;
                default: n = 0;
            endcase
            bad = (rd && wr) || (n == 0);
            if (!bad) bad = (wr && funct3[2]) || (rd && funct3[2] && n == 4) || ((a % n) != 0);
            if (bad) begin
                e_valid = 1'b1;
                e_err   = 1'b1;
                e_rd    = '0;
            end else if (rd) begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | ({24'h0, mb[a + i]} << (8*i));
                if (!funct3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
                e_rd    = v;
                e_valid = 1'b1;
            end else if (n == 4) begin
                for (int i = 0; i < 4; i++) mb[a + i] = wr_data[8*i +: 8];
                e_valid = 1'b1;
            end else begin
                m_busy = 1'b1;
                p_addr = a;
                p_n    = n;
                p_data = wr_data;
            end
        end
        e_busy = m_busy;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_busy  = 1'b0;
                e_valid = 1'b0;
                e_err   = 1'b0;
                e_busy  = 1'b0;
                e_rd    = '0;
            end else begin
                model_step();
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("cyc_resp_valid", {31'b0, resp_valid}, {31'b0, e_valid});
            chk("cyc_err",        {31'b0, err},        {31'b0, e_err});
            chk("cyc_busy",       {31'b0, busy},       {31'b0, e_busy});
            chk("cyc_rd_data",    rd_data,             e_rd);
        end
    end

    always @(negedge clk) if (resp_valid) pulses++;

    // ------------------------------------------------------------------
    // Stimulus helpers: called #1 after a rising edge; return #1 after the
    // edge that accepted the request (i.e. in the cycle of an N+1 response).
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic r, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input logic [2:0] f);
        int waits = 0;
        rd = r; wr = w; addr = a; wr_data = d; funct3 = f;
        while (busy && waits < 8) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (waits >= 8) begin
            n_checks++;
            $display("FAIL issue_timeout: busy still %0d after %0d cycles, required 0", busy, waits);
        end
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    int p0;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_rd_data",    rd_data, 32'h0);
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("reset_busy",       {31'b0, busy}, 32'h0);
        chk("reset_err",        {31'b0, err}, 32'h0);
        chk_on = 1'b1;
        idle(1);

        // word store then load
        issue(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010);
        chk("sw_resp", {31'b0, resp_valid}, 32'h1);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
        chk("lw_010", rd_data, 32'hDEADBEEF);
        chk("lw_010_err", {31'b0, err}, 32'h0);

        // byte store via read-modify-write
        issue(1'b0, 1'b1, 9'h011, 32'h000000AA, 3'b000);
        chk("sb_busy", {31'b0, busy}, 32'h1);
        chk("sb_no_resp_n1", {31'b0, resp_valid}, 32'h0);
        idle(1);
        chk("sb_resp_n2", {31'b0, resp_valid}, 32'h1);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
        chk("lw_after_sb", rd_data, 32'hDEADAAEF);
        issue(1'b1, 1'b0, 9'h011, 32'h0, 3'b000);
        chk("lb_011", rd_data, 32'hFFFFFFAA);
        issue(1'b1, 1'b0, 9'h011, 32'h0, 3'b100);
        chk("lbu_011", rd_data, 32'h000000AA);

        // halfword store
        issue(1'b0, 1'b1, 9'h012, 32'h00001234, 3'b001);
        idle(1);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
        chk("lw_after_sh", rd_data, 32'h1234AAEF);
        issue(1'b1, 1'b0, 9'h012, 32'h0, 3'b001);
        chk("lh_012", rd_data, 32'h00001234);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b001);
        chk("lh_010", rd_data, 32'hFFFFAAEF);

        // error cases
        issue(1'b1, 1'b0, 9'h013, 32'h0, 3'b010);
        chk("lw_mis_err", {31'b0, err}, 32'h1);
        chk("lw_mis_rd", rd_data, 32'h0);
        chk("lw_mis_resp", {31'b0, resp_valid}, 32'h1);
        issue(1'b0, 1'b1, 9'h011, 32'h0000BEEF, 3'b001);
        chk("sh_mis_err", {31'b0, err}, 32'h1);
        chk("sh_mis_busy", {31'b0, busy}, 32'h0);
        issue(1'b1, 1'b1, 9'h010, 32'h55555555, 3'b010);
        chk("rdwr_err", {31'b0, err}, 32'h1);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b011);
        chk("f3_011_err", {31'b0, err}, 32'h1);
        issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
        chk("mem_unchanged", rd_data, 32'h1234AAEF);
        chk("mem_unchanged_err", {31'b0, err}, 32'h0);

        // back-to-back loads
        issue(1'b0, 1'b1, 9'h000, 32'd1, 3'b010);
        issue(1'b0, 1'b1, 9'h004, 32'd2, 3'b010);
        issue(1'b0, 1'b1, 9'h008, 32'd3, 3'b010);
        issue(1'b1, 1'b0, 9'h000, 32'h0, 3'b010);
        chk("b2b_0", rd_data, 32'd1);
        issue(1'b1, 1'b0, 9'h004, 32'h0, 3'b010);
        chk("b2b_1", rd_data, 32'd2);
        chk("b2b_1_vld", {31'b0, resp_valid}, 32'h1);
        issue(1'b1, 1'b0, 9'h008, 32'h0, 3'b010);
        chk("b2b_2", rd_data, 32'd3);
        chk("b2b_2_vld", {31'b0, resp_valid}, 32'h1);

        // sub-word store followed by a store held through busy
        issue(1'b0, 1'b1, 9'h020, 32'h11223344, 3'b010);
        idle(2);
        p0 = pulses;
        issue(1'b0, 1'b1, 9'h020, 32'h00000055, 3'b000);
        issue(1'b0, 1'b1, 9'h024, 32'hCAFEF00D, 3'b010);
        chk("held_sw_resp", {31'b0, resp_valid}, 32'h1);
        idle(3);
        chk("two_pulses", pulses - p0, 32'd2);
        issue(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        chk("lw_020", rd_data, 32'h11223355);
        issue(1'b1, 1'b0, 9'h024, 32'h0, 3'b010);
        chk("lw_024", rd_data, 32'hCAFEF00D);

        // reset in the merge cycle drops the pending write
        issue(1'b0, 1'b1, 9'h020, 32'h00000066, 3'b000);
        chk("rmw_busy", {31'b0, busy}, 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rst_rmw_rd_data", rd_data, 32'h0);
        chk("rst_rmw_resp", {31'b0, resp_valid}, 32'h0);
        chk("rst_rmw_busy", {31'b0, busy}, 32'h0);
        chk("rst_rmw_err", {31'b0, err}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        issue(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        chk("lw_020_after_rst", rd_data, 32'h11223355);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
